// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one main-memory port between instruction fetch (I)
//               and the data cache (D). Round-robin on conflict. Each access
//               is held open for MEM_LATENCY cycles, then a one-cycle done
//               pulse returns the read data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int MEM_LATENCY = 4,   // legal range 1..15
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  output logic              owner,
  output logic              busy,
  output logic              stall
);

  // Counter reload: SERVE lasts MEM_LATENCY cycles, the last one at cnt==0
  localparam logic [3:0] C_CNT_LOAD = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic        r_last_owner;
  logic        w_grant;
  logic        w_grant_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and grant decision; a conflict goes to the side not served last
  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_req || d_req) begin
          w_grant      = 1'b1;
          w_grant_d    = (i_req && d_req) ? ~r_last_owner : d_req;
          w_state_next = SERVE;
        end
      end
      SERVE: begin
        if (r_cnt == 4'd0) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Access datapath: latch request on grant, count latency, capture data and pulse done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      owner        <= 1'b0;
      r_last_owner <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      mem_we       <= 1'b0;
      i_rdata      <= 32'd0;
      d_rdata      <= 32'd0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
    end else begin
      // done is high only for the single RESP cycle
      i_done <= 1'b0;
      d_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            owner <= w_grant_d;
            r_cnt <= C_CNT_LOAD;
            if (w_grant_d) begin
              mem_addr  <= d_addr;
              mem_we    <= d_we;
              mem_wdata <= d_wdata;
            end else begin
              mem_addr  <= i_addr;
              mem_we    <= 1'b0;
              mem_wdata <= 32'd0;
            end
          end
        end
        SERVE: begin
          if (r_cnt == 4'd0) begin
            mem_we       <= 1'b0;
            r_last_owner <= owner;
            if (owner) begin
              d_done <= 1'b1;
              // writes leave the previous read data in place
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
            end else begin
              i_done  <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status to the pipeline freeze logic
  always_comb begin
    busy  = (r_state != IDLE);
    stall = (i_req & ~i_done) | (d_req & ~d_done);
  end

endmodule
`default_nettype wire
